controle_tentativas: RTL and testbench
======================================

# controle_tentativas

Round controller that sits directly upstream of the 4-bit attempts counter and drives its `load` and `decrement` inputs. It cleans two raw push-buttons (start, miss): synchronised, debounced, one pulse per press. It issues a one-cycle load to start or restart a round and a one-cycle decrement per registered miss, watching the counter's value to declare game over when attempts run out. All outputs are registered; the counter sees clean single-cycle strobes only.

## Interface
- `WIDTH`, 4: width of the counter value bus.
- `DEB_CYCLES`, 4: consecutive stable cycles required to accept a button level change; legal range 2..255.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; all state cleared while low.
- `start`  in  1  raw start button, asynchronous to `clk`, active-high.
- `miss`  in  1  raw miss button, asynchronous to `clk`, active-high.
- `count`  in  WIDTH  current value of the downstream attempts counter.
- `load`  out  1  one-cycle strobe to the counter: reload initial attempts.
- `decrement`  out  1  one-cycle strobe to the counter: consume one attempt.
- `playing`  out  1  high while a round is in progress (PLAY state).
- `game_over`  out  1  high in OVER state until the next start press.

## Operation
- Reset values: `load`=0, `decrement`=0, `playing`=0, `game_over`=0; FSM in IDLE; both debouncers stable-level 0, counters 0, press pulses 0.
- Button path (per button): two-flop synchroniser; then debounce counter. If synced level equals stable level, counter clears. If it differs, counter increments; on the cycle the counter would reach DEB_CYCLES, stable level flips and counter clears. Press pulse = one registered cycle on a 0->1 flip of the stable level. Release (1->0 flip) produces no pulse.
- FSM states: IDLE, LOAD, PLAY, OVER.
  - IDLE: start press -> LOAD. Miss presses ignored.
  - LOAD: `load`=1 for exactly this cycle -> PLAY unconditionally. Presses arriving in LOAD are dropped.
  - PLAY: `playing`=1. Start press -> LOAD (restart; priority over miss in the same cycle, no decrement). Miss press with `count`>1 -> `decrement`=1 next cycle, stay PLAY. Miss press with `count`==1 -> `decrement`=1 next cycle, -> OVER. `count`==0 with no press -> OVER (defensive; no decrement).
  - OVER: `game_over`=1, `playing`=0. Miss ignored. Start press -> LOAD.
- `decrement` is never asserted when `count`==0 and never in the same cycle as `load`.
- One physical press produces at most one strobe; holding a button produces nothing further until released and pressed again.

## Timing
- Raw button rising and stable from sampling edge E: press pulse high in the cycle after edge E+1+DEB_CYCLES. Resulting `load` or `decrement` is high in the following cycle; total latency DEB_CYCLES+2 edges.
- Glitch shorter than DEB_CYCLES cycles after synchronisation: no pulse, counter returns to 0.
- Counter updates on the edge that samples `load`/`decrement`. The next press pulse is at least 2*DEB_CYCLES cycles away, so `count` is settled before it is compared.
- `rst` low mid-round: outputs drop to reset values immediately (asynchronously); no strobe is emitted after release of reset until a fresh press.

## Structure
- Shared package: state encoding constants (IDLE=2'd0, LOAD=2'd1, PLAY=2'd2, OVER=2'd3) and the default DEB_CYCLES.
- One sub-module, `debounce_botao` (synchroniser + debounce counter + rising-edge pulse, parameter DEB_CYCLES), instantiated twice. Top holds the FSM and output registers.

## Test plan
- Reset held low 5 cycles, buttons toggling -> all outputs 0 throughout; after release, no strobes.
- `start` high 20 cycles (DEB_CYCLES=4) -> exactly one `load` pulse 6 edges after first sample; `playing`=1 next cycle.
- In PLAY with `count`=4, four clean miss presses with model counter -> four `decrement` pulses, counts 3,2,1,0; `game_over`=1 after the fourth, `playing`=0.
- `miss` glitches of 1-3 cycles in PLAY -> no `decrement`; `count` unchanged.
- In PLAY with `count`=2, start and miss press pulses in same cycle -> `load` only, no `decrement`; then in OVER, start press -> `load`, `game_over` cleared.
- Assert `rst` low mid-debounce of a miss press -> no `decrement` ever emitted for that press; FSM in IDLE.

Source files
------------

// File: rtl/controle_tentativas_pkg.sv
// Shared definitions for the round controller: FSM state encoding and
// default parameters used by the top level and the button debouncers.
package controle_tentativas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } estado_t;

  localparam int WIDTH_DEF      = 4;
  localparam int DEB_CYCLES_DEF = 4;

  // Bits needed to hold a debounce count in 0..n.
  function automatic int deb_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/controle_tentativas_if.sv
// Signal bundle between the round controller and its environment
// (raw buttons, attempts counter value, and the controller's strobes).
interface controle_tentativas_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             miss;
  logic [WIDTH-1:0] count;
  logic             load;
  logic             decrement;
  logic             playing;
  logic             game_over;

  modport master (
    output start, miss, count,
    input  load, decrement, playing, game_over
  );

  modport slave (
    input  start, miss, count,
    output load, decrement, playing, game_over
  );

endinterface

// File: rtl/controle_tentativas_debounce_botao.sv
// One raw push-button: two-flop synchroniser, debounce counter and a
// single-cycle registered pulse on each accepted press (0->1 only).
module debounce_botao
  import controle_tentativas_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = deb_cnt_width(DEB_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          pulse_q;
  logic          pulse_d;

  // The level flips on the cycle the count would reach DEB_CYCLES.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        stable_d = ~stable_q;
        pulse_d  = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/controle_tentativas.sv
// Round controller: turns debounced start/miss presses into clean load and
// decrement strobes for the attempts counter and tracks play / game-over.
module controle_tentativas
  import controle_tentativas_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  controle_tentativas_if.slave bus
);

  localparam int NBTN      = 2;
  localparam int BTN_START = 0;
  localparam int BTN_MISS  = 1;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_press;

  assign btn_raw = {bus.miss, bus.start};

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      debounce_botao #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_raw[gi]),
        .pulse_o(btn_press[gi])
      );
    end
  endgenerate

  logic    start_press;
  logic    miss_press;
  logic    count_zero;
  logic    count_one;

  assign start_press = btn_press[BTN_START];
  assign miss_press  = btn_press[BTN_MISS];
  assign count_zero  = (bus.count == '0);
  assign count_one   = (bus.count == WIDTH'(1));

  estado_t state_q;
  estado_t state_d;
  logic    dec_d;
  logic    load_q;
  logic    dec_q;
  logic    playing_q;
  logic    over_q;

  // Restart wins over a simultaneous miss; a miss never spends an attempt
  // that the counter reports it does not have.
  always_comb begin
    state_d = state_q;
    dec_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_press) state_d = LOAD;
      end
      LOAD: begin
        state_d = PLAY;
      end
      PLAY: begin
        if (start_press) begin
          state_d = LOAD;
        end else if (miss_press && !count_zero) begin
          dec_d = 1'b1;
          if (count_one) state_d = OVER;
        end else if (count_zero) begin
          state_d = OVER;
        end
      end
      OVER: begin
        if (start_press) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      dec_q     <= 1'b0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= (state_d == LOAD);
      dec_q     <= dec_d;
      playing_q <= (state_d == PLAY);
      over_q    <= (state_d == OVER);
    end
  end

  assign bus.load      = load_q;
  assign bus.decrement = dec_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = over_q;

endmodule

// File: tb/tb_controle_tentativas.sv
// Directed bench for the round controller with a downstream attempts counter
// and a window-based behavioural model compared every cycle.
module tb_controle_tentativas;

  localparam int W   = 4;
  localparam int DEB = 4;

  localparam int M_WAIT   = 0;
  localparam int M_RELOAD = 1;
  localparam int M_RUN    = 2;
  localparam int M_END    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_r = 1'b0;
  logic miss_r  = 1'b0;

  always #5 clk = ~clk;

  controle_tentativas_if #(.WIDTH(W)) bus ();

  controle_tentativas #(
    .WIDTH     (W),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int n_load = 0;
  int n_dec = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Downstream attempts counter, with a bench override to preset its value.
  logic [W-1:0] env_cnt;
  logic         force_req = 1'b1;
  logic [W-1:0] force_val = '0;

  assign bus.start = start_r;
  assign bus.miss  = miss_r;
  assign bus.count = env_cnt;

  always @(posedge clk) begin
    if (force_req)                         env_cnt <= force_val;
    else if (bus.load)                     env_cnt <= W'(4);
    else if (bus.decrement && env_cnt != 0) env_cnt <= env_cnt - 1'b1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.load === 1'b1)      n_load <= n_load + 1;
    if (bus.decrement === 1'b1) n_dec  <= n_dec + 1;
  end

  // Model: a press is accepted once the last DEB synchronised samples
  // (raw samples two edges old) all disagree with the accepted level.
  int             m_mode;
  logic [DEB+1:0] m_hist [2];
  logic           m_stable [2];
  int             m_since [2];
  logic           m_pulse [2];
  logic           e_load, e_dec, e_play, e_over;

  always @(posedge clk or negedge rst) begin : model
    int             nxt;
    logic           dec;
    logic           raw;
    logic [DEB+1:0] h;
    logic [DEB-1:0] win;
    if (!rst) begin
      m_mode <= M_WAIT;
      e_load <= 1'b0;
      e_dec  <= 1'b0;
      e_play <= 1'b0;
      e_over <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_hist[b]   <= '0;
        m_stable[b] <= 1'b0;
        m_since[b]  <= 0;
        m_pulse[b]  <= 1'b0;
      end
    end else begin
      nxt = m_mode;
      dec = 1'b0;
      if (m_mode == M_RELOAD) nxt = M_RUN;
      else if (m_pulse[0]) nxt = M_RELOAD;
      else if (m_mode == M_RUN) begin
        if (m_pulse[1] && env_cnt > 0) begin
          dec = 1'b1;
          if (int'(env_cnt) - 1 == 0) nxt = M_END;
        end else if (env_cnt == 0) begin
          nxt = M_END;
        end
      end
      m_mode <= nxt;
      e_load <= (nxt == M_RELOAD);
      e_dec  <= dec;
      e_play <= (nxt == M_RUN);
      e_over <= (nxt == M_END);
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? start_r : miss_r;
        h   = {m_hist[b][DEB:0], raw};
        win = h[DEB+1:2];
        if ((m_since[b] + 1 >= DEB) && (m_stable[b] ? (win == '0) : (&win))) begin
          m_stable[b] <= ~m_stable[b];
          m_pulse[b]  <= ~m_stable[b];
          m_since[b]  <= 0;
        end else begin
          m_pulse[b]  <= 1'b0;
          m_since[b]  <= m_since[b] + 1;
        end
        m_hist[b] <= h;
      end
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("load", bus.load, e_load);
      chk("decrement", bus.decrement, e_dec);
      chk("playing", bus.playing, e_play);
      chk("game_over", bus.game_over, e_over);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input bit is_start, input int hold, input int gap);
    if (is_start) start_r = 1'b1; else miss_r = 1'b1;
    repeat (hold) tick();
    if (is_start) start_r = 1'b0; else miss_r = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic set_count(input int v);
    force_val = W'(v);
    force_req = 1'b1;
    @(posedge clk);
    #1;
    force_req = 1'b0;
    tick();
  endtask

  initial begin : stim
    int t0;
    int load_at;
    int play_at;
    int nl;
    int d0;
    int l0;

    // Reset held with buttons toggling.
    tick();
    force_req = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_r = i[0];
      miss_r  = ~i[0];
      tick();
      chk("rst_load", bus.load, 0);
      chk("rst_playing", bus.playing, 0);
    end
    start_r = 1'b0;
    miss_r  = 1'b0;
    rst = 1'b1;
    repeat (15) tick();
    chk("post_rst_loads", n_load, 0);
    chk("post_rst_decs", n_dec, 0);

    // Start held 20 cycles: single load, six edges after first sample.
    start_r = 1'b1;
    t0 = cyc + 1;
    load_at = -1;
    play_at = -1;
    nl = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.load === 1'b1) begin
        nl++;
        if (load_at < 0) load_at = cyc;
      end
      if (bus.playing === 1'b1 && play_at < 0) play_at = cyc;
    end
    start_r = 1'b0;
    repeat (12) tick();
    chk("load_latency", load_at - t0, 6);
    chk("load_pulses", nl, 1);
    chk("playing_after_load", play_at - load_at, 1);
    chk("count_loaded", env_cnt, 4);

    // Four misses from count 4.
    d0 = n_dec;
    for (int k = 1; k <= 4; k++) begin
      press(1'b0, 8, 12);
      chk("miss_count", env_cnt, 4 - k);
      chk("miss_decs", n_dec - d0, k);
    end
    chk("over_after_4", bus.game_over, 1);
    chk("not_playing_after_4", bus.playing, 0);

    // Restart, then short miss glitches.
    press(1'b1, 8, 12);
    chk("restart_playing", bus.playing, 1);
    chk("restart_over_clr", bus.game_over, 0);
    d0 = n_dec;
    for (int g = 1; g <= 3; g++) press(1'b0, g, 10);
    chk("glitch_decs", n_dec - d0, 0);
    chk("glitch_count", env_cnt, 4);

    // Simultaneous start and miss with count 2.
    set_count(2);
    d0 = n_dec;
    l0 = n_load;
    start_r = 1'b1;
    miss_r  = 1'b1;
    repeat (8) tick();
    start_r = 1'b0;
    miss_r  = 1'b0;
    repeat (12) tick();
    chk("simul_loads", n_load - l0, 1);
    chk("simul_decs", n_dec - d0, 0);
    chk("simul_count", env_cnt, 4);

    // Exhausted counter ends the round without a decrement, start revives it.
    set_count(0);
    repeat (3) tick();
    chk("zero_over", bus.game_over, 1);
    chk("zero_no_dec", n_dec - d0, 0);
    l0 = n_load;
    press(1'b1, 8, 12);
    chk("over_restart_load", n_load - l0, 1);
    chk("over_restart_clr", bus.game_over, 0);
    chk("over_restart_play", bus.playing, 1);

    // Reset in the middle of a miss debounce.
    d0 = n_dec;
    miss_r = 1'b1;
    repeat (3) tick();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_playing", bus.playing, 0);
    tick();
    miss_r = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("rst_mid_decs", n_dec - d0, 0);
    chk("rst_mid_idle_play", bus.playing, 0);
    chk("rst_mid_idle_over", bus.game_over, 0);
    press(1'b0, 8, 12);
    chk("idle_miss_ignored", n_dec - d0, 0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
